// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the uart_xcvr block.
//   rx_state_t / tx_state_t : receiver and transmitter FSM states. The PARITY
//                             states exist only when UART_PARITY_EN is defined.
//   parity_bit()            : parity over up to 8 data bits; odd=1 gives odd
//                             parity, odd=0 gives even parity. Narrower words
//                             are zero-extended by the caller, which leaves the
//                             XOR unchanged.
// Optional feature macro: UART_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 while en_i is high
// and wraps to 0, so consecutive bit periods line up with no drift. Held at 0
// while en_i is low; clr_i restarts the period from 0 on the next cycle.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   en_i          : count enable (low forces the counter to 0)
//   clr_i         : restart the bit period
//   half_tick_o   : high on the cycle that completes CLKS_PER_BIT/2 counts
//   full_tick_o   : high on the cycle that completes CLKS_PER_BIT counts
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic half_tick_o,
    output logic full_tick_o
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || clr_i) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign half_tick_o = en_i && (cnt == HALF);
    assign full_tick_o = en_i && (cnt == LAST);

endmodule

// File: rtl/uart_xcvr.sv
// -----------------------------------------------------------------------------
// uart_xcvr
// Full-duplex UART: independent receiver and transmitter sharing one clock.
// Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS ones.
// Optional feature macro: UART_PARITY_EN (adds one parity bit per ODD_PARITY;
// without it there is no parity bit and rx_parity_err_o is tied low).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   rxd_i               : asynchronous serial input, idle high
//   txd_o               : registered serial output, idle high
//   tx_data_i/valid/ready : transmit byte handshake
//   rx_data_o/valid/ready : receive byte handshake
//   rx_frame_err_o      : 1-cycle pulse, stop bit sampled low (byte dropped)
//   rx_parity_err_o     : 1-cycle pulse, parity mismatch (byte dropped)
//   rx_overrun_o        : 1-cycle pulse, new byte lost while rx_valid_o held
//   rx_state_o/tx_state_o : current FSM states for observation
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and data stable until that edge;
// the consumer may change ready freely. tx_ready_o is high only in TX idle;
// rx_data_o never changes while rx_valid_o is high.
// -----------------------------------------------------------------------------
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxd_i,
    output logic              txd_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              rx_frame_err_o,
    output logic              rx_parity_err_o,
    output logic              rx_overrun_o,
    output logic [2:0]        rx_state_o,
    output logic [2:0]        tx_state_o
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    // ------------------------------------------------------------------ RX --
    logic      rxd_meta, rxd_sync, rxd_prev;
    rx_state_t rx_state, rx_state_nxt;
    logic      rx_half, rx_full, rx_clr;
    logic      rx_shift_en, rx_stop_sample, rx_par_bad, rx_load;
    logic [2:0]        rx_bit_cnt;
    logic [DATA_W-1:0] rx_shift;

    // Two-flop synchronizer, plus one more flop for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // The timer runs from the start edge; it is restarted at the start-bit
    // midpoint so every later full tick lands in the middle of a bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (rx_state != RX_IDLE),
        .clr_i       (rx_clr),
        .half_tick_o (rx_half),
        .full_tick_o (rx_full)
    );

`ifdef UART_PARITY_EN
    logic rx_par_sample;
`endif

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_clr         = 1'b0;
        rx_shift_en    = 1'b0;
        rx_stop_sample = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_sample  = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rxd_prev && !rxd_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_half) begin
                    if (rxd_sync) begin
                        rx_state_nxt = RX_IDLE;   // glitch, not a start bit
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_clr       = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_full) begin
                    rx_shift_en = 1'b1;
                    if (rx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_nxt = RX_PARITY;
`else
                        rx_state_nxt = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_full) begin
                    rx_par_sample = 1'b1;
                    rx_state_nxt  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Only the first stop bit is checked; a second one is idle.
                if (rx_full) begin
                    rx_stop_sample = 1'b1;
                    rx_state_nxt   = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            rx_bit_cnt <= '0;
            rx_shift   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state == RX_START) begin
                rx_bit_cnt <= '0;
            end else if (rx_shift_en) begin
                rx_bit_cnt <= rx_bit_cnt + 3'd1;
                rx_shift   <= {rxd_sync, rx_shift[DATA_W-1:1]};
            end
        end
    end

`ifdef UART_PARITY_EN
    logic [7:0] rx_word;
    logic       rx_par_mismatch;

    always_comb begin
        rx_word               = '0;
        rx_word[DATA_W-1:0]   = rx_shift;
    end

    assign rx_par_mismatch = rx_par_sample &&
                             (rxd_sync != parity_bit(rx_word, 1'(ODD_PARITY)));

    // Remembers a bad parity bit until the stop sample so the byte is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i || rx_state == RX_START) begin
            rx_par_bad <= 1'b0;
        end else if (rx_par_mismatch) begin
            rx_par_bad <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rx_parity_err_o <= 1'b0;
        else       rx_parity_err_o <= rx_par_mismatch;
    end
`else
    // Parity polarity has no effect without the parity bit.
    logic par_cfg_unused;
    assign par_cfg_unused  = 1'(ODD_PARITY);
    assign rx_par_bad      = 1'b0;
    assign rx_parity_err_o = 1'b0;
`endif

    assign rx_load = rx_stop_sample && rxd_sync && !rx_par_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_o      <= '0;
            rx_valid_o     <= 1'b0;
            rx_frame_err_o <= 1'b0;
            rx_overrun_o   <= 1'b0;
        end else begin
            rx_frame_err_o <= rx_stop_sample && !rxd_sync;
            rx_overrun_o   <= 1'b0;
            if (rx_load) begin
                // A consumer accepting on this edge frees the slot for the new byte.
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= rx_shift;
                    rx_valid_o <= 1'b1;
                end else begin
                    rx_overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------ TX --
    tx_state_t         tx_state, tx_state_nxt;
    logic              tx_full, tx_half_unused;
    logic              tx_load, tx_shift_en, tx_stop_inc, txd_nxt;
    logic [2:0]        tx_bit_cnt;
    logic              tx_stop_cnt;
    logic [DATA_W-1:0] tx_shift;

    // Runs continuously through a frame; wrapping keeps bit edges exact.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (tx_state != TX_IDLE),
        .clr_i       (1'b0),
        .half_tick_o (tx_half_unused),
        .full_tick_o (tx_full)
    );

`ifdef UART_PARITY_EN
    logic [7:0] tx_word;
    logic       tx_par;

    always_comb begin
        tx_word             = '0;
        tx_word[DATA_W-1:0] = tx_data_i;
    end

    // Parity is captured at acceptance because the shifter is consumed later.
    always_ff @(posedge clk_i) begin
        if (rst_i)        tx_par <= 1'b0;
        else if (tx_load) tx_par <= parity_bit(tx_word, 1'(ODD_PARITY));
    end
`endif

    always_comb begin
        tx_state_nxt = tx_state;
        txd_nxt      = txd_o;
        tx_load      = 1'b0;
        tx_shift_en  = 1'b0;
        tx_stop_inc  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                txd_nxt = 1'b1;
                if (tx_valid_i) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_START;
                    txd_nxt      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_full) begin
                    tx_state_nxt = TX_DATA;
                    txd_nxt      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_full) begin
                    if (tx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
                        txd_nxt      = tx_par;
`else
                        tx_state_nxt = TX_STOP;
                        txd_nxt      = 1'b1;
`endif
                    end else begin
                        tx_shift_en = 1'b1;
                        txd_nxt     = tx_shift[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_full) begin
                    tx_state_nxt = TX_STOP;
                    txd_nxt      = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                txd_nxt = 1'b1;
                if (tx_full) begin
                    tx_stop_inc = 1'b1;
                    if (tx_stop_cnt == LAST_STOP) tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state    <= TX_IDLE;
            txd_o       <= 1'b1;
            tx_shift    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            txd_o    <= txd_nxt;
            if (tx_load) begin
                tx_shift    <= tx_data_i;
                tx_bit_cnt  <= '0;
                tx_stop_cnt <= 1'b0;
            end else begin
                if (tx_shift_en) begin
                    tx_shift   <= tx_shift >> 1;
                    tx_bit_cnt <= tx_bit_cnt + 3'd1;
                end
                if (tx_stop_inc) tx_stop_cnt <= ~tx_stop_cnt;
            end
        end
    end

    assign tx_ready_o = (tx_state == TX_IDLE);
    assign rx_state_o = rx_state;
    assign tx_state_o = tx_state;

endmodule

// File: tb/tb_uart_xcvr.sv
// -----------------------------------------------------------------------------
// tb_uart_xcvr
// Directed bench for uart_xcvr at 868 clocks per bit, 8 data bits, 1 stop bit,
// even parity when UART_PARITY_EN is defined. Inputs change 1 time unit after
// the rising edge; the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_xcvr;

    localparam int CPB = 868;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       txd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_overrun;
    logic [2:0] rx_state;
    logic [2:0] tx_state;

    logic loop_en;
    logic rxd_drv;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    assign rxd = loop_en ? txd : rxd_drv;

    // ------------------------------------------------------ clock / reset --
    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_xcvr #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8),
        .STOP_BITS    (1),
        .ODD_PARITY   (0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rxd_i           (rxd),
        .txd_o           (txd),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_ready_i      (rx_ready),
        .rx_frame_err_o  (rx_frame_err),
        .rx_parity_err_o (rx_parity_err),
        .rx_overrun_o    (rx_overrun),
        .rx_state_o      (rx_state),
        .tx_state_o      (tx_state)
    );

    // ---------------------------------------------------------- scoreboard --
    int n_checks = 0;
    int n_errors = 0;
    int n_ferr   = 0;
    int n_perr   = 0;
    int n_ovr    = 0;
    int n_vrise  = 0;
    logic vld_q  = 1'b0;
    logic [7:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected_byte(input logic [7:0] act);
        n_checks = n_checks + 1;
        n_errors = n_errors + 1;
        $display("FAIL rx_unexpected: got byte %0h, required none", act);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_frame_err)          n_ferr  <= n_ferr + 1;
            if (rx_parity_err)         n_perr  <= n_perr + 1;
            if (rx_overrun)            n_ovr   <= n_ovr + 1;
            if (rx_valid && !vld_q)    n_vrise <= n_vrise + 1;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) unexpected_byte(rx_data);
                else                   check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        vld_q <= rx_valid;
    end

    // ------------------------------------------------------------- drivers --
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd_drv = b;
        tick(CPB);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ par_flip);   // even parity, optionally corrupted
`endif
        drive_bit(stop_v);
        rxd_drv = 1'b1;
        tick(4);
    endtask

    task automatic measure_busy(output int low);
        low = 0;
        while (!tx_ready && low < 2 * FRAME_BITS * CPB) begin
            low++;
            tick(1);
        end
    endtask

    // --------------------------------------------------------------- vectors --
    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vec[3];

    int f0, p0, o0, v0;
    int low1, low2;

    initial begin
        vec[0] = '{data: 8'h55, stop_v: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vec[1] = '{data: 8'h3C, stop_v: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
        vec[2] = '{data: 8'hC3, stop_v: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};

        rst      = 1'b1;
        rxd_drv  = 1'b1;
        loop_en  = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        tick(5);

        // Reset state
        check("rst txd",        {31'd0, txd},           32'd1);
        check("rst tx_ready",   {31'd0, tx_ready},      32'd1);
        check("rst rx_valid",   {31'd0, rx_valid},      32'd0);
        check("rst rx_data",    {24'd0, rx_data},       32'd0);
        check("rst errs",       {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
        check("rst states",     {26'd0, rx_state, tx_state}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Table-driven receive frames
        for (int i = 0; i < 3; i++) begin
            f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
            if (vec[i].exp_valid) exp_q.push_back(vec[i].data);
            drive_frame(vec[i].data, vec[i].stop_v);
            tick(2);
            check($sformatf("vec%0d rx_valid", i), {31'd0, rx_valid}, {31'd0, vec[i].exp_valid});
            if (vec[i].exp_valid)
                check($sformatf("vec%0d rx_data", i), {24'd0, rx_data}, {24'd0, vec[i].data});
            check($sformatf("vec%0d frame_err", i), n_ferr - f0, {31'd0, vec[i].exp_ferr});
            check($sformatf("vec%0d parity_err", i), n_perr - p0, 32'd0);
            check($sformatf("vec%0d overrun", i), n_ovr - o0, 32'd0);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            check($sformatf("vec%0d consumed", i), {31'd0, rx_valid}, 32'd0);
        end

        // Short low glitch is rejected as a false start
        f0 = n_ferr; v0 = n_vrise;
        rxd_drv = 1'b0;
        tick(200);
        rxd_drv = 1'b1;
        tick(CPB);
        check("glitch valid",     n_vrise - v0,          32'd0);
        check("glitch frame_err", n_ferr - f0,           32'd0);
        check("glitch rx_state",  {29'd0, rx_state},     32'd0);
        check("glitch rx_valid",  {31'd0, rx_valid},     32'd0);

        // Loopback, two back-to-back bytes
        f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        rx_ready = 1'b1;
        loop_en  = 1'b1;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hF0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        tick(1);
        tx_data  = 8'hF0;
        measure_busy(low1);
        tick(1);
        tx_valid = 1'b0;
        measure_busy(low2);
        tick(CPB);
        check("loop busy0",  low1, FRAME_BITS * CPB);
        check("loop busy1",  low2, FRAME_BITS * CPB);
        check("loop pending", exp_q.size(), 32'd0);
        check("loop errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 32'd0);
        check("loop txd idle", {31'd0, txd}, 32'd1);
        loop_en  = 1'b0;
        rx_ready = 1'b0;
        tick(4);

        // Overrun: second byte lost while the first is unconsumed
        o0 = n_ovr; v0 = n_vrise;
        exp_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
        tick(2);
        check("ovr rx_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr rx_data",  {24'd0, rx_data},  32'h11);
        check("ovr pulses",   n_ovr - o0,        32'd1);
        check("ovr loads",    n_vrise - v0,      32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("ovr pending", exp_q.size(), 32'd0);

`ifdef UART_PARITY_EN
        // 0x07 has even parity 1; sending 0 must be flagged and dropped
        f0 = n_ferr; p0 = n_perr; v0 = n_vrise;
        par_flip = 1'b1;
        drive_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        tick(2);
        check("par pulses",    n_perr - p0,       32'd1);
        check("par frame_err", n_ferr - f0,       32'd0);
        check("par loads",     n_vrise - v0,      32'd0);
        check("par rx_valid",  {31'd0, rx_valid}, 32'd0);
`endif

        // Reset in the middle of a TX frame and a partial RX frame
        f0 = n_ferr; p0 = n_perr; o0 = n_ovr; v0 = n_vrise;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        check("mid tx busy", {31'd0, tx_ready}, 32'd0);
        rst = 1'b1;
        tick(1);
        check("mid rst txd",      {31'd0, txd},      32'd1);
        check("mid rst tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid rst states",   {26'd0, rx_state, tx_state}, 32'd0);
        rst     = 1'b0;
        rxd_drv = 1'b1;
        tick(2 * CPB);
        check("mid rst rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid rst pulses", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0) + (n_vrise - v0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
